// File: rtl/bsg_fifo_pkt_arbiter.sv
// bsg_fifo_pkt_arbiter
//
// Round-robin, packet-locked arbiter that lets several on-chip packet
// sources share one host-bound receive FIFO slot of the AXI-Lite FIFO
// bridge. A requester is granted for exactly pkt_words_p words, so the
// words of different packets never interleave in the slot.
//
// Optional feature macro: BSG_FIFO_PKT_ARB_STATS_EN
//   defined   -> per-requester 32-bit completed-packet counters (wrapping)
//   undefined -> no counter flops, pkt_count_o tied to 0
//
// Ports
//   clk_i        : clock
//   reset_i      : asynchronous, active-high reset
//   req_v_i      : per-requester word valid
//   req_data_i   : per-requester word, requester i at [i*width_p +: width_p]
//   req_yumi_o   : per-requester dequeue (at most one bit set)
//   v_o, data_o  : output word valid / data toward the bridge slot
//   ready_i      : bridge slot ready
//   grant_id_o   : index of the locked requester (held while idle)
//   busy_o       : high while a packet is locked
//   last_o       : current output word is the last of its packet
//   pkt_count_o  : per-requester completed-packet counters, 32 bits each
module bsg_fifo_pkt_arbiter #(
  parameter int num_req_p   = 2,
  parameter int width_p     = 32,
  parameter int pkt_words_p = 4,
  localparam int id_w_lp    = (num_req_p   > 1) ? $clog2(num_req_p)   : 1,
  localparam int cnt_w_lp   = (pkt_words_p > 1) ? $clog2(pkt_words_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p-1:0]         req_v_i,
  input  logic [num_req_p*width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]         req_yumi_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_i,
  output logic [id_w_lp-1:0]           grant_id_o,
  output logic                         busy_o,
  output logic                         last_o,
  output logic [num_req_p*32-1:0]      pkt_count_o
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(pkt_words_p - 1);

  state_e               state_q, state_d;
  logic [id_w_lp-1:0]   grant_q, grant_d;
  logic [id_w_lp-1:0]   last_q, last_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic [id_w_lp-1:0]   pick;
  logic                 pick_found;
  logic                 xfer;
  logic                 last_word;
  logic [width_p-1:0]   data_arr [num_req_p];

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
    assign data_arr[gi] = req_data_i[gi*width_p +: width_p];
  end

  // Index reached by stepping d places upward from base, with wrap.
  function automatic logic [id_w_lp-1:0] rr_index(input logic [id_w_lp-1:0] base,
                                                  input int d);
    int s;
    s = int'(base) + d;
    return id_w_lp'(s % num_req_p);
  endfunction

  // Round-robin search starting just after the last completed grant;
  // d == num_req_p lands back on last_q, so a lone requester re-wins.
  always_comb begin
    pick       = last_q;
    pick_found = 1'b0;
    for (int d = 1; d <= num_req_p; d++) begin
      if (!pick_found && req_v_i[rr_index(last_q, d)]) begin
        pick       = rr_index(last_q, d);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    v_o        = 1'b0;
    xfer       = 1'b0;
    last_word  = 1'b0;
    req_yumi_o = '0;
    data_o     = data_arr[grant_q];
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        v_o                 = req_v_i[grant_q];
        xfer                = v_o & ready_i;
        req_yumi_o[grant_q] = xfer;
        last_word           = (cnt_q == cnt_last_lp);
        if (xfer) begin
          if (last_word) begin
            last_d  = grant_q;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == LOCK);
  assign last_o     = last_word;
  assign grant_id_o = grant_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= id_w_lp'(num_req_p - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BSG_FIFO_PKT_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [num_req_p];
  logic [31:0] pkt_cnt_d [num_req_p];

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
      if (xfer && last_word && (grant_q == id_w_lp'(i))) begin
        pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_req_p; i++) pkt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
    end
  end

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_pack
    assign pkt_count_o[gi*32 +: 32] = pkt_cnt_q[gi];
  end
`else
  assign pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_fifo_pkt_arbiter.sv
// Testbench for bsg_fifo_pkt_arbiter: a 2-requester / 4-word instance driven
// by directed and random traffic against a packet-level reference model,
// plus a 3-requester / 1-word instance checked for its grant rotation.
module tb_bsg_fifo_pkt_arbiter;

  localparam int N = 2;
  localparam int W = 32;
  localparam int P = 4;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [N-1:0]     req_v_i;
  logic [N*W-1:0]   req_data_i;
  logic [N-1:0]     req_yumi_o;
  logic             v_o;
  logic [W-1:0]     data_o;
  logic             ready_i;
  logic [0:0]       grant_id_o;
  logic             busy_o;
  logic             last_o;
  logic [N*32-1:0]  pkt_count_o;

  // second instance: 3 requesters, 1-word packets, 8-bit words
  logic [2:0]  v3 = 3'b111;
  logic [23:0] d3 = 24'h33_22_11;
  logic [2:0]  yumi3;
  logic        v3o, busy3, last3, rdy3;
  logic [7:0]  data3o;
  logic [1:0]  grant3;
  logic [95:0] cnt3;

  always #5 clk = ~clk;

  bsg_fifo_pkt_arbiter #(.num_req_p(N), .width_p(W), .pkt_words_p(P)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_data_i(req_data_i),
    .req_yumi_o(req_yumi_o), .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o), .last_o(last_o),
    .pkt_count_o(pkt_count_o)
  );

  bsg_fifo_pkt_arbiter #(.num_req_p(3), .width_p(8), .pkt_words_p(1)) dut3 (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(v3), .req_data_i(d3),
    .req_yumi_o(yumi3), .v_o(v3o), .data_o(data3o), .ready_i(rdy3),
    .grant_id_o(grant3), .busy_o(busy3), .last_o(last3),
    .pkt_count_o(cnt3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: packet-level view of the arbiter.
  bit          m_lock;
  int          m_grant;
  int          m_prev;
  int          m_left;
  logic [31:0] m_pk [N];
  logic [W-1:0] word [N];
  int          since_rst;
  int          yumi_seen;
  int          yumi1_seen;

  function automatic int rr_pick(input logic [N-1:0] v);
    for (int d = 1; d <= N; d++) begin
      int i;
      i = (m_prev + d) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [63:0] exp_cnt();
`ifdef BSG_FIFO_PKT_ARB_STATS_EN
    return {m_pk[1], m_pk[0]};
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_reset();
    m_lock = 1'b0; m_grant = 0; m_prev = N - 1; m_left = 0;
    for (int i = 0; i < N; i++) m_pk[i] = '0;
    since_rst = 0;
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later,
  // advance the model, then wait for the next falling edge.
  task automatic step(input logic [N-1:0] v, input logic rdy);
    logic         xf;
    logic [N-1:0] ey;
    logic [2:0]   e3;
    int           g, k;
    req_v_i    = v;
    ready_i    = rdy;
    req_data_i = {word[1], word[0]};
    #1;
    xf = m_lock && v[m_grant] && rdy;
    ey = '0;
    if (xf) ey[m_grant] = 1'b1;
    check("busy", 64'(busy_o), 64'(m_lock));
    check("v_o", 64'(v_o), 64'(m_lock && v[m_grant]));
    check("yumi", 64'(req_yumi_o), 64'(ey));
    check("last", 64'(last_o), 64'(m_lock && (m_left == 1)));
    check("grant_id", 64'(grant_id_o), 64'(m_grant));
    if (m_lock) check("data", 64'(data_o), 64'(word[m_grant]));
    check("pkt_count", pkt_count_o, exp_cnt());
    if (req_yumi_o != '0) yumi_seen++;
    if (req_yumi_o[1]) yumi1_seen++;
    k = since_rst;
    if (k < 8) begin
      if (k % 2 == 0) begin
        check("r3_busy", 64'(busy3), 64'd0);
        check("r3_yumi", 64'(yumi3), 64'd0);
      end else begin
        g = (k / 2) % 3;
        e3 = '0;
        e3[g] = 1'b1;
        check("r3_grant", 64'(grant3), 64'(g));
        check("r3_yumi", 64'(yumi3), 64'(e3));
        check("r3_last", 64'(last3), 64'd1);
        check("r3_data", 64'(data3o), 64'(d3[g*8 +: 8]));
      end
    end
    if (!m_lock) begin
      g = rr_pick(v);
      if (g >= 0) begin
        m_grant = g; m_lock = 1'b1; m_left = P;
      end
    end else if (xf) begin
      word[m_grant] = $urandom;
      m_left--;
      if (m_left == 0) begin
        m_lock = 1'b0;
        m_prev = m_grant;
        m_pk[m_grant] = m_pk[m_grant] + 32'd1;
      end
    end
    since_rst++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_v"}, 64'(v_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_yumi"}, 64'(req_yumi_o), 64'd0);
    check({tag, "_last"}, 64'(last_o), 64'd0);
    check({tag, "_grant"}, 64'(grant_id_o), 64'd0);
    check({tag, "_cnt"}, pkt_count_o, 64'd0);
    check({tag, "_busy3"}, 64'(busy3), 64'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit ok;
    int y0;
    logic rpat [6];
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < N; i++) word[i] = $urandom;
    reset_i = 1'b1;
    req_v_i = '0;
    ready_i = 1'b0;
    rdy3 = 1'b1;
    req_data_i = {word[1], word[0]};
    model_reset();
    since_rst = 100;
    #1;
    check_reset_outputs("rst");
    release_reset();

    // both requesting, always ready: alternating packets
    for (int i = 0; i < 20; i++) step(2'b11, 1'b1);

    // requester 0 locked, requester 1 raises valid mid-packet
    ok = 1'b0;
    for (n = 0; n < 20 && !ok; n++) begin
      if (m_lock && m_grant == 0 && m_left == P) ok = 1'b1;
      else step(2'b01, 1'b1);
    end
    check("lock0_wait", 64'(ok), 64'd1);
    yumi1_seen = 0;
    for (int i = 0; i < P; i++) step(2'b11, 1'b1);
    check("no_yumi1_in_pkt", 64'(yumi1_seen), 64'd0);

    // ready stall pattern at the start of a packet
    ok = 1'b0;
    for (n = 0; n < 20 && !ok; n++) begin
      if (m_lock && m_left == P) ok = 1'b1;
      else step(2'b11, 1'b1);
    end
    check("stall_wait", 64'(ok), 64'd1);
    y0 = yumi_seen;
    for (int i = 0; i < 6; i++) step(2'b11, rpat[i]);
    check("stall_yumis", 64'(yumi_seen - y0), 64'd4);

    // random valid / ready traffic
    for (int i = 0; i < 400; i++)
      step(N'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));

    // asynchronous reset after word 2 of a packet
    ok = 1'b0;
    for (n = 0; n < 40 && !ok; n++) begin
      if (m_lock && m_left == P - 2) ok = 1'b1;
      else step(2'b11, 1'b1);
    end
    check("midpkt_wait", 64'(ok), 64'd1);
    req_v_i = 2'b11;
    ready_i = 1'b1;
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_v", 64'(v_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_yumi", 64'(req_yumi_o), 64'd0);
    release_reset();

    // 5 packets from requester 1 only
    for (int i = 0; i < 25; i++) step(2'b10, 1'b1);
    #1;
`ifdef BSG_FIFO_PKT_ARB_STATS_EN
    check("stats_5pkts", pkt_count_o, {32'd5, 32'd0});
`else
    check("stats_5pkts", pkt_count_o, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_pkt_arbiter.md
# bsg_fifo_pkt_arbiter

Round-robin, packet-locked arbiter that shares one host-bound receive FIFO slot of the AXI-Lite FIFO bridge among several on-chip packet sources. It grants one requester at a time and holds the grant for exactly `pkt_words_p` words, so 32-bit words of one packet are never interleaved with another packet in the slot. The host then reads whole packets through the bridge's rx data/length registers. The block sits between the requesters and the bridge's `fifo_v_i`/`fifo_data_i`/`fifo_rdy_o` inputs for one slot.

## Interface
- `num_req_p`, default 2: number of requesters; must be ≥1.
- `width_p`, default 32: word width; matches the bridge FIFO width.
- `pkt_words_p`, default 4: words per packet; must be ≥1. The default matches the bridge's 4-word read length.

- `clk_i` input 1: the block's single clock.
- `reset_i` input 1: reset, asynchronous and active-high.
- `req_v_i` input `num_req_p`: per-requester word valid.
- `req_data_i` input `num_req_p`×`width_p`: per-requester word.
- `req_yumi_o` output `num_req_p`: per-requester dequeue; at most one bit is set.
- `v_o` output 1: output word valid, to the bridge `fifo_v_i[slot]`.
- `data_o` output `width_p`: output word, to the bridge `fifo_data_i[slot]`.
- `ready_i` input 1: from the bridge `fifo_rdy_o[slot]`.
- `grant_id_o` output `BSG_SAFE_CLOG2(num_req_p)`: index of the currently locked requester.
- `busy_o` output 1: high while in LOCK.
- `last_o` output 1: the current output word is the final word of its packet.
- `pkt_count_o` output `num_req_p`×32: per-requester completed-packet counters (see Configuration).

## Operation
- Two-state FSM.
  - IDLE: if any `req_v_i` bit is set, select the first set bit searching upward (with wrap) from `last_r+1` modulo `num_req_p`.
    - Register that index into `grant_r`, clear `cnt_r`, and go to LOCK.
    - No word moves in IDLE.
  - LOCK:
    - `v_o` = `req_v_i[grant_r]`.
    - `data_o` = `req_data_i[grant_r]`.
    - Transfer = `v_o & ready_i`.
    - `req_yumi_o[grant_r]` = transfer; all other yumi bits are 0.
    - Each transfer increments `cnt_r`.
    - A transfer with `cnt_r == pkt_words_p-1` is the last word: set `last_r <= grant_r` and go to IDLE.
- The grant never changes mid-packet, even if the granted requester deasserts valid (stall) or other requesters are waiting.
- `last_o` = `busy_o & (cnt_r == pkt_words_p-1)`. When `pkt_words_p == 1`, every word is last.
- `cnt_r` width is `BSG_SAFE_CLOG2(pkt_words_p)`. It never exceeds `pkt_words_p-1`.
- `grant_id_o` = `grant_r`. It holds its value in IDLE.
- A single requester re-requesting is granted again after one IDLE cycle, because the round-robin search wraps back to it.
- Reset, asserted asynchronously, including mid-packet:
  - FSM goes to IDLE; `cnt_r`, `grant_r`, and the counters go to 0.
  - `last_r` goes to `num_req_p-1`, so requester 0 has top priority after reset.
  - A partially sent packet is abandoned; requester recovery is out of scope.
- Output values during reset: `v_o`=0, `req_yumi_o`=0, `busy_o`=0, `last_o`=0, `grant_id_o`=0, `pkt_count_o`=0.

## Timing
- `v_o`, `data_o`, and `req_yumi_o` are combinational from `req_v_i`/`req_data_i`/`ready_i` in LOCK; there is no added register stage on data.
- Arbitration latency: 1 cycle, the IDLE cycle, between a request and its first word.
- Sustained throughput: `pkt_words_p` words per `pkt_words_p+1` cycles when valid and ready are held high.
- `ready_i` may fall at any cycle. The word is held and `cnt_r` is unchanged until a transfer occurs.
- State, `cnt_r`, `grant_r`, `last_r`, and the counters update only on the rising edge of `clk_i`.

## Configuration
- `BSG_FIFO_PKT_ARB_STATS_EN`
  - Defined: `pkt_count_o[i]` increments by 1 on each last-word transfer from requester i. It is 32 bits wide and wraps from 0xFFFF_FFFF to 0.
  - Undefined: no counter flops are built and `pkt_count_o` is tied to 0.

## Test plan
- Reset release with `req_v_i`=2'b11 and `ready_i`=1:
  - Cycle 0 is IDLE and grants requester 0.
  - 4 words from requester 0 follow, with `last_o` on word 4.
  - One IDLE cycle, then requester 1 sends 4 words.
  - The sequence repeats, alternating 0 and 1.
- Requester 0 locked; requester 1 raises valid mid-packet:
  - `grant_id_o` stays 0 until 4 transfers complete.
  - No `req_yumi_o[1]` pulse occurs during the packet.
- `ready_i` toggles 1,0,0,1,1,1 during LOCK:
  - Exactly 4 yumi pulses occur, only in ready cycles.
  - `data_o` is held stable across the stall.
- Reset asserted asynchronously after word 2 of a packet:
  - `v_o`, `busy_o`, and `req_yumi_o` go to 0 without a clock edge.
  - After release, requester 0 wins.
- `num_req_p`=3, `pkt_words_p`=1, all three valid: grants follow 0,1,2,0, each transfer has `last_o`=1.
- With `BSG_FIFO_PKT_ARB_STATS_EN`, after 5 packets from requester 1: `pkt_count_o[1]`=5 and the other counters are 0. Without the macro, all counters read 0.
